// File: rtl/music_select_if.sv
// Key/output bundle of the song-select stage.
// The master drives the raw keys; the slave returns song state.
interface music_select_if #(
  parameter int SONG_W = 2
);
  logic              key_next;
  logic              key_prev;
  logic              key_play;
  logic [SONG_W-1:0] music_reg;
  logic              play_en;
  logic              sel_valid;

  modport master (
    output key_next,
    output key_prev,
    output key_play,
    input  music_reg,
    input  play_en,
    input  sel_valid
  );

  modport slave (
    input  key_next,
    input  key_prev,
    input  key_play,
    output music_reg,
    output play_en,
    output sel_valid
  );
endinterface

// File: rtl/music_select.sv
// Song-select stage: key sync, debounce, press detect,
// song index and play/pause flag, all outputs registered.
module music_select #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_SONGS       = 4,
  parameter int SONG_W          = 2
) (
  input  logic           clk,
  input  logic           rst,
  music_select_if.slave  bus
);

  localparam int NK    = 3;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SONG_W-1:0] LAST =
    SONG_W'(NUM_SONGS - 1);

  // key order: [0]=next [1]=prev [2]=play
  logic [NK-1:0]    raw;
  logic [NK-1:0]    sync1_q;
  logic [NK-1:0]    sync2_q;
  logic [NK-1:0]    stable_q;
  logic [NK-1:0]    stable_d;
  logic [NK-1:0]    stable_dly_q;
  logic [NK-1:0]    press;
  logic [CNT_W-1:0] cnt_q [NK];
  logic [CNT_W-1:0] cnt_d [NK];

  logic [SONG_W-1:0] music_q;
  logic [SONG_W-1:0] music_d;
  logic              play_q;
  logic              play_d;
  logic              sel_q;
  logic              sel_d;
  logic              ev_next;
  logic              ev_prev;

  assign raw = {bus.key_play, bus.key_prev, bus.key_next};

  // two-flop synchroniser; idles released (high) out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // debounce: accept a new level after a full run of differing cycles
  always_comb begin
    for (int i = 0; i < NK; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // debounce state plus one-cycle delayed level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q     <= '1;
      stable_dly_q <= '1;
      for (int i = 0; i < NK; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < NK; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // press = debounced level falling; release is ignored
  assign press   = stable_dly_q & ~stable_q;
  assign ev_next = press[0] & ~press[1];
  assign ev_prev = press[1] & ~press[0];

  // song index wrap, play toggle and select strobe
  always_comb begin
    music_d = music_q;
    sel_d   = 1'b0;
    play_d  = play_q ^ press[2];
    unique case (1'b1)
      ev_next: begin
        music_d = (music_q >= LAST) ? '0
                                    : music_q + SONG_W'(1);
        sel_d   = 1'b1;
      end
      ev_prev: begin
        music_d = (music_q == '0 || music_q > LAST)
                  ? LAST
                  : music_q - SONG_W'(1);
        sel_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      music_q <= '0;
      play_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      music_q <= music_d;
      play_q  <= play_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.music_reg = music_q;
  assign bus.play_en   = play_q;
  assign bus.sel_valid = sel_q;

endmodule

// File: tb/tb_music_select.sv
// Bench for music_select: window-based key model,
// select-event scoreboard, directed cases plus random keys.
module tb_music_select;

  localparam int D = 4;

  typedef struct {
    int cyc;
    int mus;
    int pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kn  = 1'b1;
  logic kp  = 1'b1;
  logic ky  = 1'b1;

  always #5 clk = ~clk;

  music_select_if #(.SONG_W(2)) bus0 ();
  music_select_if #(.SONG_W(2)) bus1 ();

  assign bus0.key_next = kn;
  assign bus0.key_prev = kp;
  assign bus0.key_play = ky;
  assign bus1.key_next = kn;
  assign bus1.key_prev = kp;
  assign bus1.key_play = ky;

  music_select #(
    .DEBOUNCE_CYCLES(D),
    .NUM_SONGS(4),
    .SONG_W(2)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0.slave)
  );

  music_select #(
    .DEBOUNCE_CYCLES(D),
    .NUM_SONGS(3),
    .SONG_W(2)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   edge_n = 0;
  bit   armed  = 0;
  int   nsongs [2] = '{4, 3};
  int   m_mus  [2];
  int   m_play;
  int   stab   [3];
  bit   pend   [3];
  int   hist   [3][$];
  int   cmpv   [3][$];
  exp_t sel_q  [2][$];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d, want %0d",
               nm, edge_n, act, exp);
    end
  endtask

  // Reference: a key level is accepted once the last D
  // synchronised samples (raw delayed two edges, 1 before
  // reset release) all disagree with the accepted level.
  task automatic model_edge(bit r, bit [2:0] rawk);
    exp_t e;
    int   c;
    bit   all;
    if (r) begin
      armed = 1;
      for (int k = 0; k < 3; k++) begin
        hist[k].delete();
        cmpv[k].delete();
        stab[k] = 1;
        pend[k] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        m_mus[i] = 0;
        sel_q[i].delete();
      end
      m_play = 0;
      return;
    end
    if (pend[2]) m_play = 1 - m_play;
    if (pend[0] != pend[1]) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[0]) m_mus[i] = (m_mus[i] + 1) % nsongs[i];
        else m_mus[i] = (m_mus[i] + nsongs[i] - 1) % nsongs[i];
        e.cyc = edge_n;
        e.mus = m_mus[i];
        e.pe  = m_play;
        sel_q[i].push_back(e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0;
      hist[k].push_back(int'(rawk[k]));
      c = (hist[k].size() >= 3) ? hist[k][hist[k].size()-3] : 1;
      cmpv[k].push_back(c);
      if (cmpv[k].size() >= D) begin
        all = 1;
        for (int j = 1; j <= D; j++)
          if (cmpv[k][cmpv[k].size()-j] == stab[k]) all = 0;
        if (all) begin
          stab[k] = 1 - stab[k];
          if (stab[k] == 0) pend[k] = 1;
        end
      end
    end
  endtask

  task automatic tick(bit r, bit n, bit p, bit y);
    rst = r;
    kn  = n;
    kp  = p;
    ky  = y;
    @(posedge clk);
    edge_n++;
    model_edge(r, {y, p, n});
    @(negedge clk);
  endtask

  task automatic run(int cnt, bit r, bit n, bit p, bit y);
    repeat (cnt) tick(r, n, p, y);
  endtask

  task automatic mon(int i, int mus, int pe, int sv);
    exp_t e;
    int   exp_sv;
    exp_sv = 0;
    if (sel_q[i].size() > 0 && sel_q[i][0].cyc == edge_n)
      exp_sv = 1;
    chk($sformatf("sel_valid%0d", i), sv, exp_sv);
    if (exp_sv == 1) begin
      e = sel_q[i].pop_front();
      chk($sformatf("sel_music%0d", i), mus, e.mus);
      chk($sformatf("sel_play%0d", i), pe, e.pe);
    end
    chk($sformatf("music%0d", i), mus, m_mus[i]);
    chk($sformatf("play%0d", i), pe, m_play);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      mon(0, int'(bus0.music_reg), int'(bus0.play_en),
          int'(bus0.sel_valid));
      mon(1, int'(bus1.music_reg), int'(bus1.play_en),
          int'(bus1.sel_valid));
    end
  end

  int exp0 [4] = '{1, 2, 3, 0};
  int exp1 [4] = '{1, 2, 0, 1};

  initial begin
    // reset and idle
    run(2, 1, 1, 1, 1);
    chk("t1_rst_music", int'(bus0.music_reg), 0);
    chk("t1_rst_play", int'(bus0.play_en), 0);
    chk("t1_rst_valid", int'(bus0.sel_valid), 0);
    run(100, 0, 1, 1, 1);
    chk("t1_idle_music", int'(bus0.music_reg), 0);
    chk("t1_idle_play", int'(bus0.play_en), 0);

    // single next press: step on the 7th edge only
    for (int j = 1; j <= 20; j++) begin
      tick(0, 0, 1, 1);
      chk("t2_latency", int'(bus0.sel_valid), (j == 7) ? 1 : 0);
    end
    run(20, 0, 1, 1, 1);
    chk("t2_music", int'(bus0.music_reg), 1);

    // wrap both ways, 4 and 3 songs
    run(2, 1, 1, 1, 1);
    run(4, 0, 1, 1, 1);
    for (int p = 0; p < 4; p++) begin
      run(8, 0, 0, 1, 1);
      run(10, 0, 1, 1, 1);
      chk("t3_next4", int'(bus0.music_reg), exp0[p]);
      chk("t3_next3", int'(bus1.music_reg), exp1[p]);
    end
    run(8, 0, 1, 0, 1);
    run(10, 0, 1, 1, 1);
    chk("t3_prev4", int'(bus0.music_reg), 3);
    chk("t3_prev3", int'(bus1.music_reg), 0);

    // bounce shorter than the window
    for (int j = 0; j < 30; j++)
      tick(0, ((j / 2) % 2 == 0) ? 1'b0 : 1'b1, 1, 1);
    run(20, 0, 1, 1, 1);
    chk("t4_bounce4", int'(bus0.music_reg), 3);
    chk("t4_bounce3", int'(bus1.music_reg), 0);

    // next+prev+play together
    for (int j = 0; j < 10; j++) begin
      tick(0, 0, 0, 0);
      chk("t5_no_sel", int'(bus0.sel_valid), 0);
    end
    run(10, 0, 1, 1, 1);
    chk("t5_music", int'(bus0.music_reg), 3);
    chk("t5_play", int'(bus0.play_en), 1);

    // prev held low across reset
    run(3, 0, 1, 0, 1);
    run(2, 1, 1, 0, 1);
    for (int j = 1; j <= 15; j++) begin
      tick(0, 1, 0, 1);
      chk("t6_latency", int'(bus0.sel_valid), (j == 7) ? 1 : 0);
    end
    run(10, 0, 1, 1, 1);
    chk("t6_music4", int'(bus0.music_reg), 3);
    chk("t6_music3", int'(bus1.music_reg), 2);
    chk("t6_play", int'(bus0.play_en), 0);

    // random key levels with occasional reset
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        run(2, 1, 1, 1, 1);
      end else begin
        run(int'($urandom_range(1, 9)), 0,
            bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)));
      end
    end
    run(20, 0, 1, 1, 1);
    chk("sb_empty0", sel_q[0].size(), 0);
    chk("sb_empty1", sel_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
